board_input_conditioner: RTL and testbench



---
 rtl/board_input_conditioner.sv | 209 ++++++++++++++++++++
 tb/tb_board_input_conditioner.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_input_conditioner.sv
// Synchronises and debounces the Nexys4-DDR pushbutton and slide switches into clean
// levels and one-cycle press/release/change pulses. Optional long-press pulse: LONGPRESS_EN.
module board_input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES  = 500000,
   parameter int unsigned SW_WIDTH         = 16,
   parameter int unsigned SYNC_STAGES      = 2,
   parameter int unsigned LONGPRESS_CYCLES = 100000000
) (
   input  logic                clk_i,
   input  logic                arst_n_i,
   input  logic                btn_i,
   input  logic [SW_WIDTH-1:0] sw_i,
   output logic                btn_level_o,
   output logic                btn_press_o,
   output logic                btn_release_o,
   output logic [SW_WIDTH-1:0] sw_o,
   output logic                sw_changed_o
`ifdef LONGPRESS_EN
   ,
   output logic                long_press_o
`endif
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Elaboration-time guard against illegal parameter values.
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES must be >= 2");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be >= 2");
   end
   if (LONGPRESS_CYCLES < 2) begin : g_bad_longpress
      $error("LONGPRESS_CYCLES must be >= 2");
   end

   typedef enum logic [1:0] {
      LOW  = 2'd0,
      RISE = 2'd1,
      HIGH = 2'd2,
      FALL = 2'd3
   } btn_state_e;

   // Synchroniser chains
   logic [SYNC_STAGES-1:0]               btn_sync_q, btn_sync_d;
   logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sw_sync_q, sw_sync_d;
   logic                                 btn_s;
   logic [SW_WIDTH-1:0]                  sw_s;

   // Button debouncer
   btn_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic           level_q, level_d;
   logic           press_q, press_d;
   logic           release_q, release_d;

   // Switch filter
   logic [SW_WIDTH-1:0] sw_prev_q, sw_prev_d;
   logic [SW_WIDTH-1:0] sw_out_q, sw_out_d;
   logic [CNT_W-1:0]    swcnt_q, swcnt_d;
   logic                sw_chg_q, sw_chg_d;

   always_comb begin
      btn_sync_d = {btn_sync_q[SYNC_STAGES-2:0], btn_i};
      sw_sync_d  = {sw_sync_q[SYNC_STAGES-2:0], sw_i};
   end

   assign btn_s = btn_sync_q[SYNC_STAGES-1];
   assign sw_s  = sw_sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
         LOW: begin
            if (btn_s) begin
               state_d = RISE;
               cnt_d   = CNT_ONE;
            end
         end
         RISE: begin
            if (!btn_s) begin
               state_d = LOW;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d = HIGH;
               level_d = 1'b1;
               press_d = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         HIGH: begin
            if (!btn_s) begin
               state_d = FALL;
               cnt_d   = CNT_ONE;
            end
         end
         FALL: begin
            if (btn_s) begin
               state_d = HIGH;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d   = LOW;
               level_d   = 1'b0;
               release_d = 1'b1;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = LOW;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
   end

   // The update is only taken on a cycle where the synchronised vector is stable,
   // so the edge that first shows a new value can never be latched early.
   always_comb begin
      sw_prev_d = sw_s;
      sw_out_d  = sw_out_q;
      swcnt_d   = swcnt_q;
      sw_chg_d  = 1'b0;
      if (sw_s != sw_prev_q) begin
         swcnt_d = '0;
      end else if (swcnt_q != DEB_LAST) begin
         swcnt_d = swcnt_q + CNT_ONE;
      end else if (sw_s != sw_out_q) begin
         sw_out_d = sw_s;
         sw_chg_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         btn_sync_q <= '0;
         sw_sync_q  <= '0;
         state_q    <= LOW;
         cnt_q      <= '0;
         level_q    <= 1'b0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         sw_prev_q  <= '0;
         sw_out_q   <= '0;
         swcnt_q    <= '0;
         sw_chg_q   <= 1'b0;
      end else begin
         btn_sync_q <= btn_sync_d;
         sw_sync_q  <= sw_sync_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         level_q    <= level_d;
         press_q    <= press_d;
         release_q  <= release_d;
         sw_prev_q  <= sw_prev_d;
         sw_out_q   <= sw_out_d;
         swcnt_q    <= swcnt_d;
         sw_chg_q   <= sw_chg_d;
      end
   end

   assign btn_level_o   = level_q;
   assign btn_press_o   = press_q;
   assign btn_release_o = release_q;
   assign sw_o          = sw_out_q;
   assign sw_changed_o  = sw_chg_q;

`ifdef LONGPRESS_EN
   localparam int unsigned LCNT_W = $clog2(LONGPRESS_CYCLES) + 1;
   localparam logic [LCNT_W-1:0] LP_LAST = LCNT_W'(LONGPRESS_CYCLES - 1);
   localparam logic [LCNT_W-1:0] LP_SAT  = LCNT_W'(LONGPRESS_CYCLES);
   localparam logic [LCNT_W-1:0] LCNT_ONE = LCNT_W'(1);

   logic [LCNT_W-1:0] lcnt_q, lcnt_d;
   logic              long_q, long_d;

   // lcnt parks one past the trigger value so the pulse cannot repeat while held.
   always_comb begin
      lcnt_d = '0;
      long_d = 1'b0;
      if (state_q == HIGH) begin
         lcnt_d = (lcnt_q == LP_SAT) ? lcnt_q : lcnt_q + LCNT_ONE;
         long_d = (lcnt_q == LP_LAST);
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         lcnt_q <= '0;
         long_q <= 1'b0;
      end else begin
         lcnt_q <= lcnt_d;
         long_q <= long_d;
      end
   end

   assign long_press_o = long_q;
`endif

endmodule

// File: tb/tb_board_input_conditioner.sv
// Directed bench for board_input_conditioner: vector tables for button pulse widths and
// switch patterns, plus hand-written reset, bounce, chatter and long-press sequences.
module tb_board_input_conditioner;

   localparam int unsigned DEB  = 8;
   localparam int unsigned SYNC = 2;
   localparam int unsigned LP   = 20;
   localparam int unsigned SWW  = 16;

   logic           clk_i = 1'b0;
   logic           arst_n_i;
   logic           btn_i;
   logic [SWW-1:0] sw_i;
   logic           btn_level_o, btn_press_o, btn_release_o, sw_changed_o;
   logic [SWW-1:0] sw_o;
`ifdef LONGPRESS_EN
   logic           long_press_o;
`endif

   always #5 clk_i = ~clk_i;

   board_input_conditioner #(
      .DEBOUNCE_CYCLES (DEB),
      .SW_WIDTH        (SWW),
      .SYNC_STAGES     (SYNC),
      .LONGPRESS_CYCLES(LP)
   ) dut (
      .clk_i        (clk_i),
      .arst_n_i     (arst_n_i),
      .btn_i        (btn_i),
      .sw_i         (sw_i),
      .btn_level_o  (btn_level_o),
      .btn_press_o  (btn_press_o),
      .btn_release_o(btn_release_o),
      .sw_o         (sw_o),
      .sw_changed_o (sw_changed_o)
`ifdef LONGPRESS_EN
      ,
      .long_press_o (long_press_o)
`endif
   );

   typedef struct {
      int unsigned hi_cycles;
      int          exp_press;
      int          exp_release;
   } btn_vec_t;

   typedef struct {
      logic [SWW-1:0] val;
      logic [SWW-1:0] exp_sw;
      int             exp_changes;
      int             exp_at;
   } sw_vec_t;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc, press_cnt, rel_cnt, chg_cnt, lp_cnt, level_hi, excl_cnt;
   int press_at, rel_at, chg_at, lp_at, t_last;

   btn_vec_t btn_tab[5];
   sw_vec_t  sw_tab[4];

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_vec(input string name, input logic [SWW-1:0] act, input logic [SWW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   task automatic clear_counts();
      cyc = 0; press_cnt = 0; rel_cnt = 0; chg_cnt = 0; lp_cnt = 0; level_hi = 0;
      press_at = 0; rel_at = 0; chg_at = 0; lp_at = 0;
   endtask

   // Advance one clock edge and record what the outputs show 1 ns after it.
   task automatic step();
      @(posedge clk_i);
      #1;
      cyc++;
      if (btn_press_o)   begin press_cnt++; press_at = cyc; end
      if (btn_release_o) begin rel_cnt++;   rel_at   = cyc; end
      if (sw_changed_o)  begin chg_cnt++;   chg_at   = cyc; end
      if (btn_level_o)   level_hi++;
      if (btn_press_o && btn_release_o) excl_cnt++;
`ifdef LONGPRESS_EN
      if (long_press_o)  begin lp_cnt++;    lp_at    = cyc; end
`endif
   endtask

   initial begin
      // Widths below DEB cycles vanish; DEB and longer give one press and one release.
      btn_tab[0] = '{hi_cycles: 1,  exp_press: 0, exp_release: 0};
      btn_tab[1] = '{hi_cycles: 5,  exp_press: 0, exp_release: 0};
      btn_tab[2] = '{hi_cycles: 7,  exp_press: 0, exp_release: 0};
      btn_tab[3] = '{hi_cycles: 8,  exp_press: 1, exp_release: 1};
      btn_tab[4] = '{hi_cycles: 15, exp_press: 1, exp_release: 1};
      // A stable new vector updates on edge SYNC + DEB + 1; a repeated vector is silent.
      sw_tab[0] = '{val: 16'h0001, exp_sw: 16'h0001, exp_changes: 1, exp_at: 11};
      sw_tab[1] = '{val: 16'h0001, exp_sw: 16'h0001, exp_changes: 0, exp_at: 0};
      sw_tab[2] = '{val: 16'hFFFF, exp_sw: 16'hFFFF, exp_changes: 1, exp_at: 11};
      sw_tab[3] = '{val: 16'h0000, exp_sw: 16'h0000, exp_changes: 1, exp_at: 11};
      excl_cnt = 0;

      // Reset with inputs active: everything held at zero.
      arst_n_i = 1'b0; btn_i = 1'b1; sw_i = 16'hFFFF;
      clear_counts();
      repeat (3) step();
      check_int("rst_level", int'(btn_level_o), 0);
      check_int("rst_press", int'(btn_press_o), 0);
      check_int("rst_release", int'(btn_release_o), 0);
      check_vec("rst_sw", sw_o, 16'h0000);
      check_int("rst_swchg", int'(sw_changed_o), 0);
`ifdef LONGPRESS_EN
      check_int("rst_long", int'(long_press_o), 0);
`endif
      check_int("rst_no_pulses", press_cnt + rel_cnt + chg_cnt, 0);

      clear_counts();
      arst_n_i = 1'b1;
      repeat (15) step();
      check_int("post_rst_press_cnt", press_cnt, 1);
      check_int("post_rst_press_at", press_at, 10);
      check_int("post_rst_level", int'(btn_level_o), 1);
      check_int("post_rst_swchg_at", chg_at, 11);
      check_vec("post_rst_sw", sw_o, 16'hFFFF);

      btn_i = 1'b0; sw_i = 16'h0000;
      clear_counts();
      repeat (40) step();
      check_int("settle_release_cnt", rel_cnt, 1);
      check_int("settle_level", int'(btn_level_o), 0);
      check_vec("settle_sw", sw_o, 16'h0000);

      // Bounce: 3 high / 3 low for 40 cycles, then low.
      clear_counts();
      for (int i = 0; i < 40; i++) begin
         btn_i = ((i / 3) % 2 == 0);
         step();
      end
      btn_i = 1'b0;
      repeat (20) step();
      check_int("bounce_press", press_cnt, 0);
      check_int("bounce_release", rel_cnt, 0);
      check_int("bounce_level", level_hi, 0);

      foreach (btn_tab[k]) begin
         clear_counts();
         btn_i = 1'b1;
         repeat (btn_tab[k].hi_cycles) step();
         btn_i = 1'b0;
         repeat (40) step();
         check_int($sformatf("width%0d_press", btn_tab[k].hi_cycles), press_cnt, btn_tab[k].exp_press);
         check_int($sformatf("width%0d_release", btn_tab[k].hi_cycles), rel_cnt, btn_tab[k].exp_release);
      end

      // Clean press held 30 cycles, then clean release.
      clear_counts();
      btn_i = 1'b1;
      repeat (30) step();
      check_int("clean_press_cnt", press_cnt, 1);
      check_int("clean_press_at", press_at, 10);
      check_int("clean_level_hi", int'(btn_level_o), 1);
      check_int("clean_no_early_release", rel_cnt, 0);
      clear_counts();
      btn_i = 1'b0;
      repeat (20) step();
      check_int("clean_release_cnt", rel_cnt, 1);
      check_int("clean_release_at", rel_at, 10);
      check_int("clean_no_press", press_cnt, 0);
      check_int("clean_level_lo", int'(btn_level_o), 0);

`ifdef LONGPRESS_EN
      clear_counts();
      btn_i = 1'b1;
      repeat (50) step();
      check_int("lp_press_at", press_at, 10);
      check_int("lp_cnt", lp_cnt, 1);
      check_int("lp_at", lp_at, 30);
      btn_i = 1'b0;
      repeat (20) step();
`endif

      // Switch chatter on bit 0 while moving to A5A5.
      clear_counts();
      sw_i = 16'hA5A5;
      for (int i = 0; i < 5; i++) begin
         step();
         sw_i = (i % 2 == 0) ? 16'hA5A4 : 16'hA5A5;
      end
      step();
      sw_i = 16'hA5A5;
      t_last = cyc;
      repeat (20) step();
      check_int("chatter_chg_cnt", chg_cnt, 1);
      check_int("chatter_chg_delay", chg_at - t_last, 11);
      check_vec("chatter_sw", sw_o, 16'hA5A5);

      foreach (sw_tab[k]) begin
         clear_counts();
         sw_i = sw_tab[k].val;
         repeat (20) step();
         check_int($sformatf("swtab%0d_changes", k), chg_cnt, sw_tab[k].exp_changes);
         check_int($sformatf("swtab%0d_at", k), chg_at, sw_tab[k].exp_at);
         check_vec($sformatf("swtab%0d_sw", k), sw_o, sw_tab[k].exp_sw);
      end

      // Button and switch paths running together.
      clear_counts();
      btn_i = 1'b1; sw_i = 16'h00FF;
      repeat (20) step();
      check_int("both_press_at", press_at, 10);
      check_int("both_chg_at", chg_at, 11);
      btn_i = 1'b0;
      repeat (30) step();

      // Reset during debounce with the button held.
      clear_counts();
      btn_i = 1'b1;
      repeat (5) step();
      check_int("midrst_no_early_press", press_cnt, 0);
      arst_n_i = 1'b0;
      step();
      check_int("midrst_level", int'(btn_level_o), 0);
      check_int("midrst_pulses", press_cnt + rel_cnt, 0);
      arst_n_i = 1'b1;
      clear_counts();
      repeat (15) step();
      check_int("midrst_press_cnt", press_cnt, 1);
      check_int("midrst_press_at", press_at, 10);

      check_int("press_release_exclusive", excl_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
